// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// aes_job_scheduler : round-robin front end issuing one job at a time to a
// single AES core, returning tagged ciphertext via a one-entry response buffer
// Revision 1.0
// ============================================================================
module aes_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*128-1:0]       req_plaintext,
   input  logic [NREQ*3-1:0]         req_key_len,
   output logic                      core_start,
   output logic [127:0]              core_plaintext,
   output logic [2:0]                core_key_len,
   output logic [$clog2(NREQ)-1:0]   core_key_slot,
   output logic                      core_reset,
   input  logic                      core_ready,
   input  logic [127:0]              core_ciphertext,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [$clog2(NREQ)-1:0]   resp_id,
   output logic [127:0]              resp_data,
   output logic                      resp_err,
   output logic                      busy
);

   localparam int IDW  = $clog2(NREQ);
   localparam int CNTW = $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]      state;
   logic [1:0]      next_state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  scan_idx;
   logic            any_req;
   logic [CNTW-1:0] wait_cnt;
   logic            accept;
   logic            key_len_bad;
   logic            complete;
   logic            abort;

   logic [127:0] pt_arr [NREQ];
   logic [2:0]   kl_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign pt_arr[gi] = req_plaintext[gi*128 +: 128];
         assign kl_arr[gi] = req_key_len[gi*3 +: 3];
      end
   endgenerate

   // Scan from the slot after the last winner; NREQ is a power of two so
   // the ID arithmetic wraps naturally.
   always_comb begin
      winner   = '0;
      any_req  = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = rr_ptr + IDW'(k);
         if (!any_req && req_valid[scan_idx]) begin
            winner  = scan_idx;
            any_req = 1'b1;
         end
      end
   end

   assign key_len_bad = (kl_arr[winner] == 3'b000);
   assign accept      = (state == S_IDLE) && any_req;
   assign complete    = (state == S_WAIT) && core_ready;
   // Completion takes priority over a timeout in the same cycle.
   assign abort       = (state == S_WAIT) && !core_ready && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               next_state = key_len_bad ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: next_state = S_WAIT;
         S_WAIT: begin
            if (complete || abort) begin
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      core_start = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (accept) begin
               req_ready[winner] = 1'b1;
            end
         end
         S_ISSUE: core_start = 1'b1;
         S_RESP:  resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr         <= IDW'(NREQ - 1);
         core_plaintext <= '0;
         core_key_len   <= '0;
         core_key_slot  <= '0;
         core_reset     <= 1'b1;
         resp_id        <= '0;
         resp_data      <= '0;
         resp_err       <= 1'b0;
         wait_cnt       <= '0;
      end else begin
         core_reset <= abort;

         if (accept) begin
            rr_ptr         <= winner;
            core_plaintext <= pt_arr[winner];
            core_key_len   <= kl_arr[winner];
            core_key_slot  <= winner;
            resp_id        <= winner;
            if (key_len_bad) begin
               resp_err  <= 1'b1;
               resp_data <= '0;
            end
         end

         if (state == S_ISSUE) begin
            wait_cnt <= '0;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CNTW'(1);
         end

         if (complete) begin
            resp_data <= core_ciphertext;
            resp_err  <= 1'b0;
         end else if (abort) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Front-end scheduler for the single AES encryption core. Arbitrates round-robin among `NREQ` requesters, each presenting a plaintext block and key length. Issues one job at a time to the core, holds the core inputs stable for the whole job, and returns the ciphertext tagged with the requester ID through a one-entry response buffer. Round-key delivery stays with the external key store; this block only tells the key store which slot to serve.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; a power of 2, 2..8.
- `TIMEOUT`, 255: maximum WAIT cycles before a job is aborted; 1..65535.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request i pending.
- `req_ready` out NREQ: request i accepted this cycle; one-hot or zero.
- `req_plaintext` in NREQ*128: bits [128i+127:128i] belong to requester i.
- `req_key_len` in NREQ*3: bits [3i+2:3i]. Bit2 selects AES-256, else bit1 selects AES-192, else bit0 selects AES-128; 0 is illegal.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_plaintext` out 128: held for the whole job.
- `core_key_len` out 3: held for the whole job.
- `core_key_slot` out log2(NREQ): key-store slot, equal to the granted requester ID; held for the whole job.
- `core_reset` out 1: core reset, registered. Equals reset OR the abort pulse.
- `core_ready` in 1: core done flag. The core clears it the cycle after it accepts a start and sets it at completion.
- `core_ciphertext` in 128: valid while core_ready=1.
- `resp_valid` out 1; `resp_ready` in 1: response handshake.
- `resp_id` out log2(NREQ), `resp_data` out 128, `resp_err` out 1: response payload.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **Reset values:**
  - All outputs 0 and state = IDLE.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - core_reset = 1 during reset and for the first cycle after it.
- **IDLE**
  - Winner = first i with req_valid[i], scanning from pointer+1 and wrapping modulo NREQ.
  - req_ready[winner] = 1, combinational, only in IDLE. No other requester sees req_ready.
  - On accept: latch plaintext, key_len and ID into core_* and resp_id; pointer ← winner.
  - If key_len == 0: go directly to RESP with resp_err=1 and resp_data=0. The core is never started.
  - Otherwise go to ISSUE.
- **ISSUE**
  - core_start=1 for exactly this one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If core_ready=1: capture core_ciphertext into resp_data, set resp_err=0, go to RESP. A stale core_ready from the previous job is impossible: the core clears it on the ISSUE edge.
  - Else if the counter reaches TIMEOUT: pulse core_reset for one cycle, set resp_err=1 and resp_data=0, go to RESP.
  - If core_ready and timeout occur in the same cycle, completion wins.
- **RESP**
  - resp_valid=1 and the payload is stable until resp_valid && resp_ready.
  - On that handshake go to IDLE. The next grant is evaluated in that IDLE cycle, never in the RESP cycle.
- Requester inputs may change after acceptance without effect on the job in flight.
- Reset mid-job: return to IDLE immediately and drop the in-flight job. No response is produced. core_reset is asserted.

## Timing
- **Accept to core_start:** accept at cycle t (IDLE, req_valid & req_ready); core_start at t+1.
- **Core latency L:** first WAIT cycle is t+2. If core_ready is seen at cycle t+1+L, resp_valid rises at t+2+L.
- **Illegal key_len:** resp_valid at t+1.
- **Back-to-back throughput:** response handshake at cycle r; next accept earliest at r+1.
- **Timeout:** abort after exactly TIMEOUT WAIT cycles with core_ready low. core_reset is high on the cycle after the last WAIT cycle; resp_valid rises the same cycle.
- The counter is wide enough for TIMEOUT; it never wraps.

## Test plan
- **Single AES-128 job:** requester 2, pt=00112233445566778899aabbccddeeff, key_len=3'b001, core model with L=12.
  - core_start pulses once at t+1; core_key_slot=2.
  - resp_valid at t+14 with resp_id=2, err=0 and the model's ciphertext.
- **Round-robin fairness:** all 4 req_valid held high, resp_ready=1.
  - Grant order 0,1,2,3,0.
  - Never two req_ready bits high at once.
- **Illegal key length:** key_len=0 on requester 1.
  - resp_valid at t+1 with id=1, err=1, data=0.
  - core_start never asserted.
- **Timeout:** TIMEOUT=20, core model never raises ready.
  - core_reset pulses one cycle after 20 WAIT cycles.
  - resp_err=1 with resp_data=0.
- **Response backpressure:** resp_ready held low 10 cycles with a second request pending.
  - Payload stable throughout; req_ready stays 0.
  - Second accept occurs the cycle after the handshake.
- **Mid-job reset:** reset asserted during WAIT.
  - Next cycle: state IDLE, busy=0, resp_valid=0, core_reset=1.
  - Requester 0 wins the next arbitration.
